// File: rtl/sobel_stage.sv
// Streaming 3x3 Sobel edge stage between two FWFT FIFOs, border pixels forced to 0.
// Optional SOBEL_THRESHOLD_EN binarizes the magnitude against THRESHOLD.
module sobel_stage #(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 540,
  parameter int THRESHOLD = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_dout,
  input  logic       in_empty,
  output logic       in_rd_en,
  output logic [7:0] out_din,
  input  logic       out_full,
  output logic       out_wr_en
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int DW = $clog2(WIDTH + 1);

  if (WIDTH < 3 || HEIGHT < 3 || THRESHOLD < 0) begin : g_bad_cfg
    $error("sobel_stage: unsupported parameters");
  end

  typedef enum logic [1:0] {
    FILL,
    RUN,
    DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            vld_q, vld_d;
  logic [7:0]      out_q, out_d;

  logic [7:0]      lb0_q [WIDTH];
  logic [7:0]      lb1_q [WIDTH];
  // Two window columns (c-1, c); column c+1 arrives with the current pop.
  logic [7:0]      w_q   [3][2];

  logic            slot;
  logic            advance;
  logic            last_col;
  logic            last_row;
  logic            fill_done;
  logic            border;
  logic [7:0]      top;
  logic [7:0]      mid;
  logic signed [11:0] gx;
  logic signed [11:0] gy;
  logic [11:0]     ax;
  logic [11:0]     ay;
  logic [7:0]      mag;
  logic [7:0]      edge_px;
  logic [7:0]      res;

  function automatic logic signed [11:0] sx(input logic [7:0] p);
    return signed'({4'b0000, p});
  endfunction

  assign slot      = ~vld_q | ~out_full;
  assign last_col  = col_q == CW'(WIDTH - 1);
  assign last_row  = row_q == RW'(HEIGHT - 1);
  assign fill_done = (row_q == RW'(1)) && (col_q == '0);
  assign border    = (row_q < RW'(2)) || (col_q < CW'(2));

  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      FILL, RUN: advance = ~in_empty & slot;
      DRAIN:     advance = slot;
      default:   advance = 1'b0;
    endcase
    advance = advance & ~reset;
  end

  assign in_rd_en  = advance & (state_q != DRAIN);
  assign out_wr_en = vld_q & ~out_full & ~reset;
  assign out_din   = out_q;

  assign top = lb1_q[col_q];
  assign mid = lb0_q[col_q];

  always_comb begin
    gx = (sx(top) + sx(mid) + sx(mid) + sx(in_dout))
       - (sx(w_q[0][0]) + sx(w_q[1][0]) + sx(w_q[1][0]) + sx(w_q[2][0]));
    gy = (sx(w_q[2][0]) + sx(w_q[2][1]) + sx(w_q[2][1]) + sx(in_dout))
       - (sx(w_q[0][0]) + sx(w_q[0][1]) + sx(w_q[0][1]) + sx(top));
    ax = gx[11] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[11] ? $unsigned(-gy) : $unsigned(gy);
    mag = ((ax + ay) > 12'd511) ? 8'hFF : 8'((ax + ay) >> 1);
`ifdef SOBEL_THRESHOLD_EN
    edge_px = (int'(mag) > THRESHOLD) ? 8'hFF : 8'h00;
`else
    edge_px = mag;
`endif
    res = border ? 8'h00 : edge_px;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dcnt_d  = dcnt_q;
    vld_d   = vld_q;
    out_d   = out_q;
    if (out_wr_en) vld_d = 1'b0;
    if (advance) begin
      if (state_q != DRAIN) begin
        if (last_col) begin
          col_d = '0;
          row_d = last_row ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      unique case (state_q)
        FILL: begin
          if (fill_done) state_d = RUN;
        end
        RUN: begin
          vld_d = 1'b1;
          out_d = res;
          if (last_row && last_col) state_d = DRAIN;
        end
        DRAIN: begin
          vld_d = 1'b1;
          out_d = 8'h00;
          if (dcnt_q == DW'(WIDTH)) begin
            dcnt_d  = '0;
            col_d   = '0;
            row_d   = '0;
            state_d = FILL;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      dcnt_q  <= '0;
      vld_q   <= 1'b0;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clock) begin
    if (in_rd_en) begin
      lb1_q[col_q] <= mid;
      lb0_q[col_q] <= in_dout;
      for (int r = 0; r < 3; r++) w_q[r][0] <= w_q[r][1];
      w_q[0][1] <= top;
      w_q[1][1] <= mid;
      w_q[2][1] <= in_dout;
    end
  end

endmodule

// File: doc/sobel_stage.md
# sobel_stage

Streaming 3x3 Sobel edge-detection stage that sits directly downstream of the grayscale stage in `dut_system`. It pops 8-bit grayscale pixels in raster order from a first-word-fall-through FIFO. It pushes one 8-bit edge-magnitude pixel per input pixel into the next FIFO. Frames are WIDTH x HEIGHT and processed back-to-back; border pixels are forced to zero so the output frame keeps the input size.

## Interface
- WIDTH, 720, pixels per line (>= 3)
- HEIGHT, 540, lines per frame (>= 3)
- THRESHOLD, 64, binarization threshold (used only with SOBEL_THRESHOLD_EN)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_dout  in  8  grayscale pixel at head of upstream FIFO
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pop upstream FIFO
- out_din  out  8  edge pixel to downstream FIFO
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push downstream FIFO

## Operation
- Two line buffers of WIDTH x 8 bits plus a 3x3 register window, shifted one pixel per advance.
- Column counter 0..WIDTH-1 and row counter 0..HEIGHT-1 track the incoming pixel; both wrap at the end of the frame.
- The output pixel for centre (r,c) is computed when input pixel (r+1,c+1) is consumed. This gives a fixed delay of WIDTH+1 pixels.
- gx = (p02+2p12+p22)-(p00+2p10+p20); gy = (p20+2p21+p22)-(p00+2p01+p02), using 12-bit signed arithmetic.
- mag = (|gx|+|gy|)>>1, saturated to 255.
- Centres with r=0, r=HEIGHT-1, c=0 or c=WIDTH-1 produce 0.
- State machine:
  - FILL: consume the first WIDTH+1 pixels of a frame with no output. Go to RUN after the (WIDTH+1)th pop.
  - RUN: each pop produces one output. Go to DRAIN after the last pixel of the frame is popped.
  - DRAIN: emit the remaining WIDTH+1 outputs without popping; all are border pixels, so all are 0. Then clear counters and go to FILL.
- Output register has a valid flag. Advance condition:
  - RUN/FILL: advance = ~in_empty & (~out_valid | ~out_full).
  - DRAIN: advance = ~out_valid | ~out_full.
- in_rd_en = advance in FILL/RUN, 0 in DRAIN.
- out_wr_en = out_valid & ~out_full. The valid flag clears on a write unless it is reloaded in the same cycle.
- The block never writes while out_full=1 and never reads while in_empty=1.
- Per frame, exactly WIDTH*HEIGHT pops and WIDTH*HEIGHT pushes occur.

## Timing
- Reset values: in_rd_en=0, out_wr_en=0, out_din=0, state=FILL, counters=0, out_valid=0. Line buffer contents are don't-care.
- Reset asserted mid-frame abandons the frame. The next pixel popped after reset is treated as (0,0).
- in_rd_en and out_wr_en are combinational from registered state plus in_empty/out_full.
- out_din is registered.
- Output appears on out_din one cycle after the advance that computes it.
- Sustained throughput is 1 pixel/cycle when the input is never empty and the output is never full.
- First push of a frame: 1 cycle after the (WIDTH+2)th pop.
- Simultaneous write and reload of the output register in one cycle is legal and keeps out_wr_en high.
- DRAIN of frame N completes before any pop of frame N+1. The gap between frames is WIDTH+1 cycles.

## Configuration
- SOBEL_THRESHOLD_EN defined: out_din = 255 if mag > THRESHOLD, else 0. Border pixels are still 0.
- SOBEL_THRESHOLD_EN undefined: out_din = saturated mag. The THRESHOLD parameter is ignored.

## Test plan
- Flat frame, WIDTH=HEIGHT=4, all pixels 128 -> 16 pushes, all 0, then state returns to FILL.
- Vertical step, WIDTH=HEIGHT=4, columns 0-1 = 0 and columns 2-3 = 255 -> interior centres (1,1),(1,2),(2,1),(2,2) = 255; all border pixels = 0.
- Ramp, 5x5, pixel = 10*col -> gx=80, gy=0, so interior = 40. With SOBEL_THRESHOLD_EN and THRESHOLD=64, interior = 0; with THRESHOLD=30, interior = 255.
- Back-pressure: toggle out_full every other cycle and in_empty randomly on a 720x540 frame -> exactly 388800 pushes, no write while full, no read while empty, output identical to the unstalled run.
- Reset asserted mid-RUN (after 1000 pops), then a full 4x4 frame -> 16 correct outputs and no stale data from before the reset.
- Two back-to-back 4x4 frames -> 32 pushes, and the second frame's results are independent of the first.
